arith_rs: RTL and testbench

Parametrised arithmetic reservation station for the Tomasulo core. It sits between the dispatch stage and the integer ALU/multiplier result path. It holds up to DEPTH renamed instructions and captures operands from N_CDB common data bus channels, including same-cycle bypass at dispatch. It issues the oldest ready entry each cycle into a one-entry result register, which the CDB arbiter drains through a valid/ready handshake; a flush input discards all speculative state.

---
 rtl/arith_rs_if.sv | 47 ++++
 rtl/arith_rs.sv | 226 ++++++++++++++++++++++
 tb/tb_arith_rs.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_rs_if.sv
// Port bundle of the arithmetic reservation station: dispatch, CDB snoop and result.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// valid never depends on ready, ready never depends on valid, and a held result
// (res_valid=1) keeps res_tag/res_data stable until it is taken.
interface arith_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 4,
  parameter int N_CDB  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      disp_valid;
  logic                      disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [TAG_W-1:0]          disp_dest;
  logic [DATA_W-1:0]         disp_data1;
  logic [DATA_W-1:0]         disp_data2;
  logic [TAG_W-1:0]          disp_q1;
  logic [TAG_W-1:0]          disp_q2;

  logic [N_CDB-1:0]          cdb_valid;
  logic [N_CDB*TAG_W-1:0]    cdb_tag;
  logic [N_CDB*DATA_W-1:0]   cdb_data;

  logic                      res_valid;
  logic                      res_ready;
  logic [TAG_W-1:0]          res_tag;
  logic [DATA_W-1:0]         res_data;

  logic [CNT_W-1:0]          count;

  modport master (
    output disp_valid, disp_op, disp_dest, disp_data1, disp_data2, disp_q1, disp_q2,
    output cdb_valid, cdb_tag, cdb_data,
    output res_ready,
    input  disp_ready, res_valid, res_tag, res_data, count
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest, disp_data1, disp_data2, disp_q1, disp_q2,
    input  cdb_valid, cdb_tag, cdb_data,
    input  res_ready,
    output disp_ready, res_valid, res_tag, res_data, count
  );
endinterface

// File: rtl/arith_rs.sv
// Arithmetic reservation station: holds renamed instructions, snoops the CDB for
// operands and issues the oldest ready entry into a one-entry result register.
module arith_rs #(
  parameter int               DATA_W      = 32,
  parameter int               TAG_W       = 6,
  parameter int               OP_W        = 6,
  parameter int               DEPTH       = 4,
  parameter int               N_CDB       = 2,
  parameter logic [TAG_W-1:0] INVALID_TAG = TAG_W'(16)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  arith_rs_if.slave  bus
);
  localparam int AGE_W = $clog2(DEPTH);
  localparam int IDX_W = AGE_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5);

  // Entry storage
  logic              busy_q [DEPTH];
  logic              busy_d [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [DATA_W-1:0] v1_q   [DEPTH];
  logic [DATA_W-1:0] v1_d   [DEPTH];
  logic [TAG_W-1:0]  q1_q   [DEPTH];
  logic [TAG_W-1:0]  q1_d   [DEPTH];
  logic [DATA_W-1:0] v2_q   [DEPTH];
  logic [DATA_W-1:0] v2_d   [DEPTH];
  logic [TAG_W-1:0]  q2_q   [DEPTH];
  logic [TAG_W-1:0]  q2_d   [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [AGE_W-1:0]  age_d  [DEPTH];

  // Result register
  logic              res_valid_q, res_valid_d;
  logic [TAG_W-1:0]  res_tag_q,   res_tag_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;

  // Combinational status
  logic [CNT_W-1:0]  cnt;
  logic              disp_ready;
  logic              disp_fire;
  logic              rdy     [DEPTH];
  logic [CNT_W-1:0]  older_n [DEPTH];
  logic              can_age [DEPTH];
  logic              iss_found;
  logic              iss_fire;
  logic [IDX_W-1:0]  iss_idx;
  logic [AGE_W-1:0]  iss_age;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;

  function automatic logic [DATA_W-1:0] alu(input logic [OP_W-1:0]   op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD, OP_ADDI: r = a + b;
      OP_SUB:          r = a - b;
      OP_SLL:          r = a << b[SH_W-1:0];
      OP_SRL:          r = a >> b[SH_W-1:0];
      OP_MUL:          r = a * b;
      default:         r = '0;
    endcase
    return r;
  endfunction

  // Occupancy, readiness, oldest-ready pick and lowest free slot, all from registered state
  always_comb begin
    cnt        = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    iss_age    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = busy_q[i] && (q1_q[i] == INVALID_TAG) && (q2_q[i] == INVALID_TAG);
      if (busy_q[i]) cnt = cnt + CNT_W'(1);
      if (rdy[i] && (!iss_found || (age_q[i] > iss_age))) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
        iss_age   = age_q[i];
      end
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    disp_ready = (cnt < CNT_W'(DEPTH));
    disp_fire  = bus.disp_valid && disp_ready;
    iss_fire   = iss_found && (!res_valid_q || bus.res_ready);
  end

  // Saturation is collective: an entry only ages while there is an unused age
  // above it, so ages stay distinct and keep dispatch order even after gaps.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_n[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (busy_q[j] && (age_q[j] > age_q[i])) older_n[i] = older_n[i] + CNT_W'(1);
      end
      can_age[i] = (int'(older_n[i]) + int'(age_q[i])) < (DEPTH - 1);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = busy_q[i];
      dest_d[i] = dest_q[i];
      op_d[i]   = op_q[i];
      v1_d[i]   = v1_q[i];
      q1_d[i]   = q1_q[i];
      v2_d[i]   = v2_q[i];
      q2_d[i]   = q2_q[i];
      age_d[i]  = age_q[i];
    end
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;

    // Wakeup: descending scan so the lowest matching channel is written last
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && (q1_q[i] != INVALID_TAG)) begin
        for (int k = N_CDB - 1; k >= 0; k--) begin
          if (bus.cdb_valid[k] && (bus.cdb_tag[k*TAG_W +: TAG_W] == q1_q[i])) begin
            v1_d[i] = bus.cdb_data[k*DATA_W +: DATA_W];
            q1_d[i] = INVALID_TAG;
          end
        end
      end
      if (busy_q[i] && (q2_q[i] != INVALID_TAG)) begin
        for (int k = N_CDB - 1; k >= 0; k--) begin
          if (bus.cdb_valid[k] && (bus.cdb_tag[k*TAG_W +: TAG_W] == q2_q[i])) begin
            v2_d[i] = bus.cdb_data[k*DATA_W +: DATA_W];
            q2_d[i] = INVALID_TAG;
          end
        end
      end
      if (busy_q[i] && disp_fire && can_age[i]) age_d[i] = age_q[i] + AGE_W'(1);
    end

    if (iss_fire) begin
      busy_d[iss_idx] = 1'b0;
      res_valid_d     = 1'b1;
      res_tag_d       = dest_q[iss_idx];
      res_data_d      = alu(op_q[iss_idx], v1_q[iss_idx], v2_q[iss_idx]);
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    // The free slot is never the one issuing this cycle, so there is no same-cycle reuse
    if (disp_fire) begin
      busy_d[free_idx] = 1'b1;
      dest_d[free_idx] = bus.disp_dest;
      op_d[free_idx]   = bus.disp_op;
      age_d[free_idx]  = '0;
      v1_d[free_idx]   = bus.disp_data1;
      q1_d[free_idx]   = bus.disp_q1;
      v2_d[free_idx]   = bus.disp_data2;
      q2_d[free_idx]   = bus.disp_q2;
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if ((bus.disp_q1 != INVALID_TAG) && bus.cdb_valid[k] &&
            (bus.cdb_tag[k*TAG_W +: TAG_W] == bus.disp_q1)) begin
          v1_d[free_idx] = bus.cdb_data[k*DATA_W +: DATA_W];
          q1_d[free_idx] = INVALID_TAG;
        end
        if ((bus.disp_q2 != INVALID_TAG) && bus.cdb_valid[k] &&
            (bus.cdb_tag[k*TAG_W +: TAG_W] == bus.disp_q2)) begin
          v2_d[free_idx] = bus.cdb_data[k*DATA_W +: DATA_W];
          q2_d[free_idx] = INVALID_TAG;
        end
      end
    end
  end

  // Flush behaves exactly like reset: everything speculative is dropped
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        dest_q[i] <= '0;
        op_q[i]   <= '0;
        v1_q[i]   <= '0;
        q1_q[i]   <= INVALID_TAG;
        v2_q[i]   <= '0;
        q2_q[i]   <= INVALID_TAG;
        age_q[i]  <= '0;
      end
      res_valid_q <= 1'b0;
      res_tag_q   <= INVALID_TAG;
      res_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= busy_d[i];
        dest_q[i] <= dest_d[i];
        op_q[i]   <= op_d[i];
        v1_q[i]   <= v1_d[i];
        q1_q[i]   <= q1_d[i];
        v2_q[i]   <= v2_d[i];
        q2_q[i]   <= q2_d[i];
        age_q[i]  <= age_d[i];
      end
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.disp_ready = disp_ready;
  assign bus.count      = cnt;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_data   = res_data_q;
endmodule

// File: tb/tb_arith_rs.sv
// Bench for arith_rs: directed scenarios plus random traffic, checked every cycle
// against an in-order queue model of the station and a result scoreboard.
module tb_arith_rs;
  localparam int         DW    = 32;
  localparam int         TW    = 6;
  localparam int         OW    = 6;
  localparam int         DEPTH = 4;
  localparam int         NCDB  = 2;
  localparam logic [5:0] INV   = 6'd16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  always #5 clock = ~clock;

  arith_rs_if #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW), .DEPTH(DEPTH), .N_CDB(NCDB)) bus ();

  arith_rs #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW), .DEPTH(DEPTH), .N_CDB(NCDB),
             .INVALID_TAG(INV)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Reference model: pending instructions kept oldest-first
  typedef struct {
    logic [5:0]  dest;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [5:0]  q1;
    logic [31:0] v2;
    logic [5:0]  q2;
  } ent_t;

  ent_t         rs_q[$];
  logic         m_res_valid = 1'b0;
  logic [5:0]   m_res_tag   = INV;
  logic [31:0]  m_res_data  = '0;
  logic [37:0]  exp_q[$];

  logic         obs_valid = 1'b0;
  logic [5:0]   obs_tag   = '0;
  logic [31:0]  obs_data  = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      6'd0, 6'd1: return a + b;
      6'd2:       return a - b;
      6'd3:       return a << (b % 32);
      6'd4:       return a >> (b % 32);
      6'd5: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      default:    return 32'd0;
    endcase
  endfunction

  // Operand capture from the CDB inputs as they stand now; lowest channel wins
  task automatic snoop(inout logic [31:0] v, inout logic [5:0] q);
    logic hit;
    hit = 1'b0;
    if (q != INV) begin
      for (int k = 0; k < NCDB; k++) begin
        if (!hit && bus.cdb_valid[k] && (bus.cdb_tag[k*6 +: 6] == q)) begin
          v   = bus.cdb_data[k*32 +: 32];
          q   = INV;
          hit = 1'b1;
        end
      end
    end
  endtask

  task automatic model_step();
    ent_t e;
    int   sel;
    logic room;
    if (reset || flush) begin
      rs_q.delete();
      exp_q.delete();
      m_res_valid = 1'b0;
      m_res_tag   = INV;
      m_res_data  = '0;
      return;
    end
    room = (rs_q.size() < DEPTH);
    sel  = -1;
    if (!m_res_valid || bus.res_ready) begin
      for (int i = 0; i < rs_q.size(); i++) begin
        if (sel < 0 && rs_q[i].q1 == INV && rs_q[i].q2 == INV) sel = i;
      end
    end
    if (m_res_valid && bus.res_ready) m_res_valid = 1'b0;
    if (sel >= 0) begin
      e           = rs_q[sel];
      m_res_valid = 1'b1;
      m_res_tag   = e.dest;
      m_res_data  = ref_alu(e.op, e.v1, e.v2);
      exp_q.push_back({m_res_tag, m_res_data});
      rs_q.delete(sel);
    end
    for (int i = 0; i < rs_q.size(); i++) begin
      e = rs_q[i];
      snoop(e.v1, e.q1);
      snoop(e.v2, e.q2);
      rs_q[i] = e;
    end
    if (bus.disp_valid && room) begin
      e.dest = bus.disp_dest;
      e.op   = bus.disp_op;
      e.v1   = bus.disp_data1;
      e.q1   = bus.disp_q1;
      e.v2   = bus.disp_data2;
      e.q2   = bus.disp_q2;
      snoop(e.v1, e.q1);
      snoop(e.v2, e.q2);
      rs_q.push_back(e);
    end
  endtask

  // One clock: scoreboard the handshake, step the model, then check all outputs
  task automatic cycle();
    logic        hs;
    logic [37:0] e;
    hs = obs_valid && bus.res_ready && !reset && !flush;
    @(posedge clock);
    if (hs) begin
      chk("sb_has_exp", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_result", {26'd0, obs_tag, obs_data}, {26'd0, e});
      end
    end
    model_step();
    #1;
    chk("res_valid", 64'(bus.res_valid), 64'(m_res_valid));
    if (m_res_valid) begin
      chk("res_tag", 64'(bus.res_tag), 64'(m_res_tag));
      chk("res_data", 64'(bus.res_data), 64'(m_res_data));
    end
    chk("count", 64'(bus.count), 64'(rs_q.size()));
    chk("disp_ready", 64'(bus.disp_ready), 64'(rs_q.size() < DEPTH));
    obs_valid = bus.res_valid;
    obs_tag   = bus.res_tag;
    obs_data  = bus.res_data;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [5:0] dest, input logic [31:0] d1,
                      input logic [5:0] q1, input logic [31:0] d2, input logic [5:0] q2);
    bus.disp_valid = 1'b1;
    bus.disp_op    = op;
    bus.disp_dest  = dest;
    bus.disp_data1 = d1;
    bus.disp_q1    = q1;
    bus.disp_data2 = d2;
    bus.disp_q2    = q2;
  endtask

  task automatic cdb(input int ch, input logic [5:0] tag, input logic [31:0] data);
    bus.cdb_valid[ch]        = 1'b1;
    bus.cdb_tag[ch*6 +: 6]   = tag;
    bus.cdb_data[ch*32 +: 32] = data;
  endtask

  initial begin
    bus.disp_valid = 1'b0;
    bus.disp_op    = '0;
    bus.disp_dest  = '0;
    bus.disp_data1 = '0;
    bus.disp_data2 = '0;
    bus.disp_q1    = INV;
    bus.disp_q2    = INV;
    bus.cdb_valid  = '0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;
    bus.res_ready  = 1'b1;

    // Reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_tag", 64'(bus.res_tag), 64'(INV));

    // add tag 3: 5+7, both present
    disp(6'd0, 6'd3, 32'd5, INV, 32'd7, INV);
    cycle();
    chk("add_cnt1", 64'(bus.count), 64'd1);
    idle();
    cycle();
    chk("add_valid", 64'(bus.res_valid), 64'd1);
    chk("add_tag", 64'(bus.res_tag), 64'd3);
    chk("add_data", 64'(bus.res_data), 64'd12);
    chk("add_cnt0", 64'(bus.count), 64'd0);
    cycle();

    // sub tag 4 waiting on tag 9, woken by CDB channel 1
    disp(6'd2, 6'd4, 32'd0, 6'd9, 32'd2, INV);
    cycle();
    idle();
    cycle();
    cycle();
    cdb(1, 6'd9, 32'd10);
    cycle();
    chk("sub_wait", 64'(bus.res_valid), 64'd0);
    idle();
    cycle();
    chk("sub_tag", 64'(bus.res_tag), 64'd4);
    chk("sub_data", 64'(bus.res_data), 64'd8);
    cycle();

    // mul with same-cycle bypass of operand 1 on channel 0
    disp(6'd5, 6'd5, 32'd0, 6'd7, 32'd7, INV);
    cdb(0, 6'd7, 32'd6);
    cycle();
    idle();
    cycle();
    chk("byp_tag", 64'(bus.res_tag), 64'd5);
    chk("byp_data", 64'(bus.res_data), 64'd42);
    cycle();

    // Full station under back-pressure, then age-ordered release
    bus.res_ready = 1'b0;
    disp(6'd0, 6'd20, 32'd1, INV, 32'd1, INV);
    cycle();
    for (int i = 0; i < 4; i++) begin
      disp(6'd0, 6'(10 + i), 32'd0, 6'(1 + i), 32'd1, INV);
      cycle();
    end
    chk("full_cnt0", 64'(bus.count), 64'd4);
    chk("full_rdy0", 64'(bus.disp_ready), 64'd0);
    disp(6'd0, 6'd30, 32'd9, INV, 32'd9, INV);
    cdb(0, 6'd4, 32'd100);
    cycle();
    chk("full_rdy1", 64'(bus.disp_ready), 64'd0);
    chk("full_cnt1", 64'(bus.count), 64'd4);
    idle();
    bus.disp_valid = 1'b1;
    cdb(0, 6'd1, 32'd50);
    cycle();
    chk("full_rdy2", 64'(bus.disp_ready), 64'd0);
    chk("full_hold", 64'(bus.res_tag), 64'd20);
    idle();
    bus.res_ready = 1'b1;
    cycle();
    chk("ord1_tag", 64'(bus.res_tag), 64'd10);
    chk("ord1_data", 64'(bus.res_data), 64'd51);
    chk("ord1_cnt", 64'(bus.count), 64'd3);
    cycle();
    chk("ord2_tag", 64'(bus.res_tag), 64'd13);
    chk("ord2_data", 64'(bus.res_data), 64'd101);
    chk("ord2_cnt", 64'(bus.count), 64'd2);
    cdb(0, 6'd2, 32'd0);
    cdb(1, 6'd3, 32'd0);
    cycle();
    idle();
    repeat (4) cycle();

    // Shift wrap, multiply overflow, undefined opcode
    disp(6'd3, 6'd21, 32'd1, INV, 32'd33, INV);
    cycle();
    idle();
    cycle();
    chk("sll_data", 64'(bus.res_data), 64'd2);
    disp(6'd5, 6'd22, 32'hFFFF_FFFF, INV, 32'd2, INV);
    cycle();
    idle();
    cycle();
    chk("mulw_data", 64'(bus.res_data), 64'hFFFF_FFFE);
    disp(6'h3F, 6'd23, 32'd5, INV, 32'd6, INV);
    cycle();
    idle();
    cycle();
    chk("undef_valid", 64'(bus.res_valid), 64'd1);
    chk("undef_tag", 64'(bus.res_tag), 64'd23);
    chk("undef_data", 64'(bus.res_data), 64'd0);
    cycle();

    // Flush with three busy entries, a held result and a dispatch in flight
    bus.res_ready = 1'b0;
    disp(6'd0, 6'd40, 32'd1, INV, 32'd2, INV);
    cycle();
    for (int i = 0; i < 3; i++) begin
      disp(6'd0, 6'(41 + i), 32'd0, 6'd60, 32'd0, INV);
      cycle();
    end
    chk("pre_fl_cnt", 64'(bus.count), 64'd3);
    chk("pre_fl_valid", 64'(bus.res_valid), 64'd1);
    flush = 1'b1;
    disp(6'd0, 6'd44, 32'd1, INV, 32'd1, INV);
    cycle();
    flush = 1'b0;
    idle();
    chk("fl_cnt", 64'(bus.count), 64'd0);
    chk("fl_valid", 64'(bus.res_valid), 64'd0);
    chk("fl_ready", 64'(bus.disp_ready), 64'd1);
    bus.res_ready = 1'b1;
    cdb(0, 6'd60, 32'd1);
    cycle();
    idle();
    cycle();
    cycle();
    chk("fl_nores", 64'(bus.res_valid), 64'd0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      bus.res_ready  = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 99) == 0);
      bus.disp_valid = $urandom_range(0, 1) == 1;
      bus.disp_op    = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 5));
      bus.disp_dest  = 6'($urandom_range(0, 63));
      bus.disp_data1 = $urandom;
      bus.disp_data2 = $urandom;
      bus.disp_q1    = ($urandom_range(0, 1) == 1) ? INV : 6'($urandom_range(0, 15));
      bus.disp_q2    = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 15)) : INV;
      for (int k = 0; k < NCDB; k++) begin
        bus.cdb_valid[k]       = ($urandom_range(0, 2) == 0);
        bus.cdb_tag[k*6 +: 6]  = 6'($urandom_range(0, 15));
        bus.cdb_data[k*32 +: 32] = $urandom;
      end
      cycle();
    end

    // Drain: wake every outstanding tag and accept all results
    flush          = 1'b0;
    bus.res_ready  = 1'b1;
    bus.disp_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.cdb_valid = '0;
      if (c < 16) begin
        cdb(0, 6'(c % 16), $urandom);
        cdb(1, 6'((c + 8) % 16), $urandom);
      end
      cycle();
    end
    chk("drain_cnt", 64'(bus.count), 64'd0);
    chk("drain_valid", 64'(bus.res_valid), 64'd0);
    chk("drain_sb", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
